// File: rtl/mux_sel_unit.sv
// Datapath selection primitive: combinational 2:1 and 4:1 selects built from a
// shared AND-OR 2:1 stage, plus an enabled, synchronously reset copy of the 4:1 result.

module mux_sel_unit_mux2 #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_s,
   output logic [WIDTH-1:0] o_y
);

   logic [WIDTH-1:0] w_s;

   assign w_s = {WIDTH{i_s}};
   assign o_y = (i_a & ~w_s) | (i_b & w_s);

endmodule

module mux_sel_unit #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [1:0]       sel,
   input  logic             en,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out4_q,
   output logic             valid_q
);

   logic [WIDTH-1:0] w_lo;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_out4;
   logic [WIDTH-1:0] r_out4_q;
   logic             r_valid_q;

   // The low first-level stage doubles as the 2:1 output.
   mux_sel_unit_mux2 #(.WIDTH(WIDTH)) u_lo (
      .i_a (i0),
      .i_b (i1),
      .i_s (sel[0]),
      .o_y (w_lo)
   );

   mux_sel_unit_mux2 #(.WIDTH(WIDTH)) u_hi (
      .i_a (i2),
      .i_b (i3),
      .i_s (sel[0]),
      .o_y (w_hi)
   );

   mux_sel_unit_mux2 #(.WIDTH(WIDTH)) u_out (
      .i_a (w_lo),
      .i_b (w_hi),
      .i_s (sel[1]),
      .o_y (w_out4)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out4_q  <= '0;
         r_valid_q <= 1'b0;
      end else if (en) begin
         r_out4_q  <= w_out4;
         r_valid_q <= 1'b1;
      end
   end

   assign out2    = w_lo;
   assign out4    = w_out4;
   assign out4_q  = r_out4_q;
   assign valid_q = r_valid_q;

endmodule

// File: tb/tb_mux_sel_unit.sv
// Self-checking bench for mux_sel_unit: directed plan, an 8:1 tiling, and randomized cycles.

module tb_mux_sel_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] i0, i1, i2, i3;
   logic [1:0] sel;
   logic       en;
   logic [7:0] out2, out4, out4_q;
   logic       valid_q;

   logic [7:0] c_in;
   logic [2:0] c_sel;
   logic       a_out2, a_out4, a_q, a_v;
   logic       b_out2, b_out4, b_q, b_v;
   logic       m_out2, m_out4, m_q, m_v;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q = '0;
   logic       exp_v = 1'b0;

   always #5 clk = ~clk;

   mux_sel_unit #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .sel(sel), .en(en), .out2(out2), .out4(out4), .out4_q(out4_q), .valid_q(valid_q)
   );

   mux_sel_unit #(.WIDTH(1)) u_a (
      .clk(clk), .reset(reset), .i0(c_in[0]), .i1(c_in[1]), .i2(c_in[2]), .i3(c_in[3]),
      .sel(c_sel[1:0]), .en(1'b0), .out2(a_out2), .out4(a_out4), .out4_q(a_q), .valid_q(a_v)
   );

   mux_sel_unit #(.WIDTH(1)) u_b (
      .clk(clk), .reset(reset), .i0(c_in[4]), .i1(c_in[5]), .i2(c_in[6]), .i3(c_in[7]),
      .sel(c_sel[1:0]), .en(1'b0), .out2(b_out2), .out4(b_out4), .out4_q(b_q), .valid_q(b_v)
   );

   mux_sel_unit #(.WIDTH(1)) u_m (
      .clk(clk), .reset(reset), .i0(a_out4), .i1(b_out4), .i2(1'b0), .i3(1'b0),
      .sel({1'b0, c_sel[2]}), .en(1'b0), .out2(m_out2), .out4(m_out4), .out4_q(m_q), .valid_q(m_v)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // Reference: a lane is picked by indexing the lane array with sel.
   task automatic chk_comb(input string tag);
      logic [7:0] lanes [4];
      lanes[0] = i0; lanes[1] = i1; lanes[2] = i2; lanes[3] = i3;
      chk({tag, ".out4"}, out4, lanes[sel]);
      chk({tag, ".out2"}, out2, lanes[{1'b0, sel[0]}]);
   endtask

   task automatic tick(input string tag);
      logic [7:0] lanes [4];
      lanes[0] = i0; lanes[1] = i1; lanes[2] = i2; lanes[3] = i3;
      @(posedge clk);
      if (reset) begin
         exp_q = '0;
         exp_v = 1'b0;
      end else if (en) begin
         exp_q = lanes[sel];
         exp_v = 1'b1;
      end
      #1;
      chk({tag, ".out4_q"}, out4_q, exp_q);
      chk({tag, ".valid_q"}, {7'd0, valid_q}, {7'd0, exp_v});
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] exp8 [2];
      exp8[0] = 8'b1100_1010;
      exp8[1] = 8'b0011_0101;

      reset = 1'b1; en = 1'b0; sel = 2'd0;
      i0 = '0; i1 = '0; i2 = '0; i3 = '0;
      c_in = '0; c_sel = '0;
      #2;
      tick("reset0");
      tick("reset1");

      // Lane pattern 1010 (and its inverse) replicated across all bits.
      for (int p = 0; p < 2; p++) begin
         pat = (p == 0) ? 8'h0A : 8'h05;
         i0 = {8{pat[0]}}; i1 = {8{pat[1]}}; i2 = {8{pat[2]}}; i3 = {8{pat[3]}};
         for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            #10;
            chk_comb($sformatf("sweep%0d_sel%0d", p, s));
            chk($sformatf("sweep%0d_sel%0d.abs", p, s), {7'd0, out4[0]}, {7'd0, (p == 0) ? s[0] : ~s[0]});
         end
      end

      // 8:1 composition out of three instances.
      for (int p = 0; p < 2; p++) begin
         c_in = (p == 0) ? 8'hCA : 8'h35;
         for (int s = 0; s < 8; s++) begin
            c_sel = s[2:0];
            #10;
            chk($sformatf("mux8_%0d_sel%0d", p, s), {7'd0, m_out2}, {7'd0, exp8[p][s]});
         end
      end

      // Registered path.
      @(negedge clk);
      reset = 1'b0;
      i0 = 8'h11; i1 = 8'h22; i2 = 8'h44; i3 = 8'h88;
      sel = 2'd2; en = 1'b1;
      tick("load44");
      chk("load44.abs", out4_q, 8'h44);
      en = 1'b0; sel = 2'd3;
      #1;
      chk_comb("hold");
      tick("hold");
      chk("hold.abs", out4_q, 8'h44);
      chk("hold.out4abs", out4, 8'h88);

      reset = 1'b1; en = 1'b1;
      tick("rst_en0");
      tick("rst_en1");
      chk("rst_en.abs", out4_q, 8'h00);
      chk_comb("in_reset");
      reset = 1'b0; sel = 2'd1;
      tick("rel_load");
      chk("rel_load.abs", out4_q, 8'h22);
      sel = 2'd3;
      tick("load88");
      reset = 1'b1; sel = 2'd0;
      #1;
      chk_comb("mid_reset");
      tick("mid_reset");
      chk("mid_reset.abs", out4_q, 8'h00);
      reset = 1'b0;

      // Randomized cycles against the reference.
      for (int n = 0; n < 200; n++) begin
         i0 = 8'($urandom); i1 = 8'($urandom); i2 = 8'($urandom); i3 = 8'($urandom);
         sel = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 2) != 0);
         reset = ($urandom_range(0, 15) == 0);
         #1;
         chk_comb("rand");
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_sel_unit.md
Name: mux_sel_unit

Overview:
- Gate-level selection primitive for the datapath muxes.
- Provides a combinational 2:1 select, a combinational 4:1 select, and a registered copy of the 4:1 result.
- The 4:1 path is built from three 2:1 stages: two first-level stages steered by sel[0], one output stage steered by sel[1].
- Wider muxes (8:1, 32:1, register-file read ports) are built by tiling this block: two 4:1 results combined by a 2:1 stage on the next select bit.

Parameters:
WIDTH, 1, bit width of each data lane; all lanes are selected bitwise with the same select.

Ports:
clk  input  1  rising-edge clock for the registered output only
reset  input  1  synchronous, active-high; clears registered outputs
i0  input  WIDTH  lane 0
i1  input  WIDTH  lane 1
i2  input  WIDTH  lane 2
i3  input  WIDTH  lane 3
sel  input  2  lane select; sel[0] = low select bit, sel[1] = high select bit
en  input  1  load enable for out4_q
out2  output  WIDTH  combinational 2:1 result
out4  output  WIDTH  combinational 4:1 result
out4_q  output  WIDTH  registered 4:1 result
valid_q  output  1  high once out4_q holds a loaded value

Behaviour:
- out2:
  - out2 = sel[0] ? i1 : i0.
  - Purely combinational; independent of sel[1], clk and reset.
- out4:
  - lo = sel[0] ? i1 : i0; hi = sel[0] ? i3 : i2; out4 = sel[1] ? hi : lo.
  - Result: sel 0→i0, 1→i1, 2→i2, 3→i3.
  - Combinational; zero cycles of latency.
- Bitwise operation:
  - Bit k of each output depends only on bit k of the lanes and on sel.
  - No cross-bit interaction.
- Every 2:1 stage is a single shared 2:1 primitive (AND-OR form: (i0 & ~s) | (i1 & s)). out4 reuses the out2 stage as its lo stage.
- Sel hazards: no latches. All assignments are fully specified for every sel value.
- Registered path, evaluated on rising clk:
  - reset = 1: out4_q <= 0 and valid_q <= 0. Reset takes priority over en.
  - reset = 0, en = 1: out4_q <= out4 value at the edge; valid_q <= 1.
  - reset = 0, en = 0: out4_q and valid_q hold.
- Latency: out4_q reflects inputs/sel sampled at the previous rising edge (1 cycle).
- Reset mid-operation: on the edge where reset is high, out4_q clears to 0 regardless of en or data. The first load occurs on the first edge with reset low and en high.
- Out-of-reset state:
  - out4_q = 0, valid_q = 0.
  - out2 and out4 are valid whenever inputs are stable, including during reset.
- Input changes between edges do not affect out4_q until the next enabled edge.

Test Plan:
- WIDTH=1, lanes {i3,i2,i1,i0}=4'b1010, sweep sel 0..3 with 10 ns steps -> out4 = 0,1,0,1; out2 = 0,1,0,1.
- Same sweep with lanes inverted (4'b0101) -> out4 = 1,0,1,0. Confirms every lane is reachable with both polarities.
- Two instances plus one 2:1 stage composed as 8:1, in=8'hCA, sel 0..7 -> out = 0,1,0,1,0,0,1,1. Then in=8'h35 -> 1,0,1,0,1,1,0,0.
- WIDTH=8, i0=8'h11, i1=8'h22, i2=8'h44, i3=8'h88:
  - sel=2, en=1, one edge -> out4_q=8'h44, valid_q=1.
  - Then en=0, sel=3 -> out4_q stays 8'h44 while out4=8'h88.
- Hold reset=1 with en=1 and nonzero lanes for 2 edges -> out4_q=0, valid_q=0. Release reset -> next edge loads the selected lane.
- Assert reset for one edge after out4_q=8'h88 -> out4_q=0 at that edge. out2 and out4 keep tracking inputs throughout.
